// File: rtl/mc_sequencer.sv
// Multi-cycle control sequencer: drives datapath selects through an FSM with
// memory request/ready handshakes, bounded waits, HALT/illegal-opcode traps and a retire counter.
module mc_sequencer #(
    parameter int WIDTH_OPCODE = 4,
    parameter int ALU_OP_WIDTH = 3,
    parameter int WAIT_LIMIT   = 15,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH_OPCODE-1:0] opcode,
    input  logic                    zero,
    input  logic                    imem_ready,
    input  logic                    dmem_ready,
    output logic                    imem_req,
    output logic                    dmem_req,
    output logic                    IR_Write,
    output logic                    pc_write_enable,
    output logic                    RegWrite,
    output logic                    MemToReg,
    output logic                    Mem_Select,
    output logic                    Mem_Read_not_Write,
    output logic [1:0]              PC_Source,
    output logic                    alu_src_a,
    output logic [1:0]              alu_src_b,
    output logic [ALU_OP_WIDTH-1:0] ALUop,
    output logic                    halted,
    output logic                    error,
    output logic [COUNT_WIDTH-1:0]  instr_count,
    output logic [3:0]              state
);

    localparam int WCW = $clog2(WAIT_LIMIT + 1);

    localparam logic [WIDTH_OPCODE-1:0] OP_NOP  = WIDTH_OPCODE'(0);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADD  = WIDTH_OPCODE'(1);
    localparam logic [WIDTH_OPCODE-1:0] OP_SUB  = WIDTH_OPCODE'(2);
    localparam logic [WIDTH_OPCODE-1:0] OP_AND  = WIDTH_OPCODE'(3);
    localparam logic [WIDTH_OPCODE-1:0] OP_OR   = WIDTH_OPCODE'(4);
    localparam logic [WIDTH_OPCODE-1:0] OP_ADDI = WIDTH_OPCODE'(5);
    localparam logic [WIDTH_OPCODE-1:0] OP_LW   = WIDTH_OPCODE'(6);
    localparam logic [WIDTH_OPCODE-1:0] OP_SW   = WIDTH_OPCODE'(7);
    localparam logic [WIDTH_OPCODE-1:0] OP_BEQ  = WIDTH_OPCODE'(8);
    localparam logic [WIDTH_OPCODE-1:0] OP_JMP  = WIDTH_OPCODE'(9);
    localparam logic [WIDTH_OPCODE-1:0] OP_HALT = '1;

    localparam logic [ALU_OP_WIDTH-1:0] ALU_ADD = ALU_OP_WIDTH'(0);
    localparam logic [ALU_OP_WIDTH-1:0] ALU_SUB = ALU_OP_WIDTH'(1);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_WB_ALU = 4'd5,
        S_ADDR   = 4'd6,
        S_MEM    = 4'd7,
        S_WB_MEM = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_HALT   = 4'd11,
        S_ERROR  = 4'd12
    } state_t;

    state_t           state_q, state_d;
    logic [WCW-1:0]   wait_cnt;
    logic             timeout;
    logic             waiting;
    logic             retire;

    assign timeout = (wait_cnt == WCW'(WAIT_LIMIT));
    assign waiting = ((state_q == S_FETCH) && !imem_ready) ||
                     ((state_q == S_MEM)   && !dmem_ready);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter is zero on every entry into FETCH/MEM because any non-waiting cycle clears it.
    always_ff @(posedge clock) begin
        if (reset || !waiting || timeout) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset || (state_q == S_RESET)) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_RESET:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem_ready)   state_d = S_DECODE;
                else if (timeout) state_d = S_ERROR;
            end
            S_DECODE: begin
                case (opcode)
                    OP_NOP: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR: state_d = S_EXEC_R;
                    OP_ADDI:                       state_d = S_EXEC_I;
                    OP_LW, OP_SW:                  state_d = S_ADDR;
                    OP_BEQ:                        state_d = S_BRANCH;
                    OP_JMP:                        state_d = S_JUMP;
                    OP_HALT:                       state_d = S_HALT;
                    default:                       state_d = S_ERROR;
                endcase
            end
            S_EXEC_R: state_d = S_WB_ALU;
            S_EXEC_I: state_d = S_WB_ALU;
            S_WB_ALU: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_ADDR:   state_d = S_MEM;
            S_MEM: begin
                if (dmem_ready) begin
                    if (opcode == OP_LW) begin
                        state_d = S_WB_MEM;
                    end else begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = S_ERROR;
                end
            end
            S_WB_MEM, S_BRANCH, S_JUMP: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            S_ERROR:  state_d = S_ERROR;
            default:  state_d = S_RESET;
        endcase
    end

    always_comb begin
        imem_req           = 1'b0;
        dmem_req           = 1'b0;
        IR_Write           = 1'b0;
        pc_write_enable    = 1'b0;
        RegWrite           = 1'b0;
        MemToReg           = 1'b0;
        Mem_Select         = 1'b0;
        Mem_Read_not_Write = 1'b1;
        PC_Source          = 2'd0;
        alu_src_a          = 1'b0;
        alu_src_b          = 2'd0;
        ALUop              = ALU_ADD;
        halted             = 1'b0;
        error              = 1'b0;
        case (state_q)
            S_RESET: begin
                pc_write_enable = 1'b1;
                PC_Source       = 2'd3;
            end
            S_FETCH: begin
                imem_req  = 1'b1;
                alu_src_b = 2'd1;
                if (imem_ready) begin
                    IR_Write        = 1'b1;
                    pc_write_enable = 1'b1;
                end
            end
            S_DECODE: alu_src_b = 2'd2;
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                ALUop     = ALU_OP_WIDTH'(opcode - WIDTH_OPCODE'(1));
            end
            S_EXEC_I, S_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'd2;
            end
            S_WB_ALU: RegWrite = 1'b1;
            S_MEM: begin
                dmem_req           = 1'b1;
                Mem_Select         = 1'b1;
                Mem_Read_not_Write = (opcode == OP_LW);
            end
            S_WB_MEM: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                ALUop     = ALU_SUB;
                if (zero) begin
                    pc_write_enable = 1'b1;
                    PC_Source       = 2'd1;
                end
            end
            S_JUMP: begin
                pc_write_enable = 1'b1;
                PC_Source       = 2'd2;
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: error  = 1'b1;
            default: ;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Bench for mc_sequencer: per-instruction expected state traces are queued, then
// popped cycle by cycle while handshake inputs are driven; a 4-bit-counter twin checks wrap.
module tb_mc_sequencer;

    localparam logic [3:0] ST_RESET  = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_EXEC_I = 4'd4;
    localparam logic [3:0] ST_WB_ALU = 4'd5;
    localparam logic [3:0] ST_ADDR   = 4'd6;
    localparam logic [3:0] ST_MEM    = 4'd7;
    localparam logic [3:0] ST_WB_MEM = 4'd8;
    localparam logic [3:0] ST_BRANCH = 4'd9;
    localparam logic [3:0] ST_JUMP   = 4'd10;
    localparam logic [3:0] ST_HALT   = 4'd11;
    localparam logic [3:0] ST_ERROR  = 4'd12;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_ADDI = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd6;
    localparam logic [3:0] OP_SW   = 4'd7;
    localparam logic [3:0] OP_BEQ  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam int LIMIT = 15;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  opcode = '0;
    logic        zero = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;

    logic        imem_req, dmem_req, IR_Write, pc_write_enable, RegWrite, MemToReg;
    logic        Mem_Select, Mem_Read_not_Write, alu_src_a, halted, error;
    logic [1:0]  PC_Source, alu_src_b;
    logic [2:0]  ALUop;
    logic [15:0] instr_count;
    logic [3:0]  state;

    logic        s_imem_req, s_dmem_req, s_IR_Write, s_pc_write_enable, s_RegWrite, s_MemToReg;
    logic        s_Mem_Select, s_Mem_Read_not_Write, s_alu_src_a, s_halted, s_error;
    logic [1:0]  s_PC_Source, s_alu_src_b;
    logic [2:0]  s_ALUop;
    logic [3:0]  s_instr_count;
    logic [3:0]  s_state;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_count = '0;
    logic [3:0]  exp_q[$];

    always #5 clock = ~clock;

    mc_sequencer #(.WIDTH_OPCODE(4), .ALU_OP_WIDTH(3), .WAIT_LIMIT(LIMIT), .COUNT_WIDTH(16)) u_dut (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .IR_Write(IR_Write),
        .pc_write_enable(pc_write_enable), .RegWrite(RegWrite), .MemToReg(MemToReg),
        .Mem_Select(Mem_Select), .Mem_Read_not_Write(Mem_Read_not_Write),
        .PC_Source(PC_Source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ALUop(ALUop), .halted(halted), .error(error),
        .instr_count(instr_count), .state(state)
    );

    mc_sequencer #(.WIDTH_OPCODE(4), .ALU_OP_WIDTH(3), .WAIT_LIMIT(LIMIT), .COUNT_WIDTH(4)) u_small (
        .clock(clock), .reset(reset), .opcode(opcode), .zero(zero),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(s_imem_req), .dmem_req(s_dmem_req), .IR_Write(s_IR_Write),
        .pc_write_enable(s_pc_write_enable), .RegWrite(s_RegWrite), .MemToReg(s_MemToReg),
        .Mem_Select(s_Mem_Select), .Mem_Read_not_Write(s_Mem_Read_not_Write),
        .PC_Source(s_PC_Source), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
        .ALUop(s_ALUop), .halted(s_halted), .error(s_error),
        .instr_count(s_instr_count), .state(s_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero = 1'b0;
        tick();
        check("rst_state", 32'(state), 32'(ST_RESET));
        check("rst_pcsrc", 32'(PC_Source), 32'd3);
        check("rst_pcwe", 32'(pc_write_enable), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_count", 32'(instr_count), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        reset = 1'b0;
        exp_count = '0;
        tick();
    endtask

    // Starts with the DUT in FETCH; idly > LIMIT means imem_ready never comes.
    task automatic run_instr(input logic [3:0] op, input logic z, input int idly, input int ddly);
        int fcnt = 0;
        int mcnt = 0;
        bit retires = 1'b1;
        logic [3:0] st;
        opcode = op;
        zero = z;
        if (idly > LIMIT) begin
            for (int i = 0; i <= LIMIT; i++) exp_q.push_back(ST_FETCH);
            exp_q.push_back(ST_ERROR);
            exp_q.push_back(ST_ERROR);
            retires = 1'b0;
        end else begin
            for (int i = 0; i <= idly; i++) exp_q.push_back(ST_FETCH);
            exp_q.push_back(ST_DECODE);
            case (op)
                OP_NOP: ;
                OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                    exp_q.push_back(ST_EXEC_R);
                    exp_q.push_back(ST_WB_ALU);
                end
                OP_ADDI: begin
                    exp_q.push_back(ST_EXEC_I);
                    exp_q.push_back(ST_WB_ALU);
                end
                OP_LW, OP_SW: begin
                    exp_q.push_back(ST_ADDR);
                    for (int i = 0; i <= ddly; i++) exp_q.push_back(ST_MEM);
                    if (op == OP_LW) exp_q.push_back(ST_WB_MEM);
                end
                OP_BEQ: exp_q.push_back(ST_BRANCH);
                OP_JMP: exp_q.push_back(ST_JUMP);
                OP_HALT: begin
                    exp_q.push_back(ST_HALT);
                    exp_q.push_back(ST_HALT);
                    retires = 1'b0;
                end
                default: begin
                    exp_q.push_back(ST_ERROR);
                    exp_q.push_back(ST_ERROR);
                    retires = 1'b0;
                end
            endcase
        end
        while (exp_q.size() > 0) begin
            st = exp_q.pop_front();
            imem_ready = (st == ST_FETCH) && (fcnt == idly);
            dmem_ready = (st == ST_MEM) && (mcnt == ddly);
            if (st == ST_FETCH) fcnt++;
            if (st == ST_MEM) mcnt++;
            #1;
            check("state", 32'(state), 32'(st));
            check("imem_req", 32'(imem_req), 32'(st == ST_FETCH));
            check("dmem_req", 32'(dmem_req), 32'(st == ST_MEM));
            case (st)
                ST_FETCH: begin
                    check("fetch_irw", 32'(IR_Write), 32'(imem_ready));
                    check("fetch_srcb", 32'(alu_src_b), 32'd1);
                end
                ST_DECODE: check("decode_srcb", 32'(alu_src_b), 32'd2);
                ST_EXEC_R: begin
                    check("execr_aluop", 32'(ALUop), 32'(op) - 32'd1);
                    check("execr_srca", 32'(alu_src_a), 32'd1);
                end
                ST_WB_ALU: begin
                    check("wbalu_rw", 32'(RegWrite), 32'd1);
                    check("wbalu_m2r", 32'(MemToReg), 32'd0);
                end
                ST_MEM: begin
                    check("mem_rnw", 32'(Mem_Read_not_Write), 32'(op == OP_LW));
                    check("mem_sel", 32'(Mem_Select), 32'd1);
                end
                ST_WB_MEM: begin
                    check("wbmem_rw", 32'(RegWrite), 32'd1);
                    check("wbmem_m2r", 32'(MemToReg), 32'd1);
                end
                ST_BRANCH: begin
                    check("br_pcwe", 32'(pc_write_enable), 32'(z));
                    check("br_pcsrc", 32'(PC_Source), z ? 32'd1 : 32'd0);
                    check("br_aluop", 32'(ALUop), 32'd1);
                end
                ST_JUMP: begin
                    check("jmp_pcwe", 32'(pc_write_enable), 32'd1);
                    check("jmp_pcsrc", 32'(PC_Source), 32'd2);
                end
                ST_HALT: begin
                    check("halt_flag", 32'(halted), 32'd1);
                    check("halt_pcwe", 32'(pc_write_enable), 32'd0);
                end
                ST_ERROR: begin
                    check("err_flag", 32'(error), 32'd1);
                    check("err_rw", 32'(RegWrite), 32'd0);
                end
                default: ;
            endcase
            @(posedge clock);
            #1;
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        if (retires) exp_count = exp_count + 16'd1;
        check("count", 32'(instr_count), 32'(exp_count));
        check("small_count", 32'(s_instr_count), 32'(exp_count[3:0]));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #1;
        do_reset();
        run_instr(OP_NOP, 1'b0, 0, 0);
        run_instr(OP_ADDI, 1'b0, 1, 0);
        run_instr(OP_LW, 1'b0, 0, 3);
        run_instr(OP_ADD, 1'b0, 0, 0);
        run_instr(OP_SUB, 1'b0, 2, 0);
        run_instr(OP_AND, 1'b0, 0, 0);
        run_instr(OP_OR, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 2);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_JMP, 1'b0, 0, 0);
        // ready at the last permitted wait cycle completes normally
        run_instr(OP_NOP, 1'b0, LIMIT, 0);
        // ready never arrives: trap after LIMIT+1 fetch cycles
        run_instr(OP_NOP, 1'b0, LIMIT + 1, 0);

        do_reset();
        run_instr(OP_NOP, 1'b0, 0, 0);
        run_instr(4'hE, 1'b0, 0, 0);
        do_reset();
        run_instr(OP_HALT, 1'b0, 0, 0);
        do_reset();

        // reset in the middle of a data wait
        opcode = OP_LW;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        tick();
        tick();
        check("midwait_state", 32'(state), 32'(ST_MEM));
        check("midwait_dreq", 32'(dmem_req), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_state", 32'(state), 32'(ST_RESET));
        check("midrst_dreq", 32'(dmem_req), 32'd0);
        check("midrst_count", 32'(instr_count), 32'd0);
        reset = 1'b0;
        exp_count = '0;
        tick();

        for (int i = 0; i < 16; i++) run_instr(OP_NOP, 1'b0, 0, 0);
        check("wrap_small", 32'(s_instr_count), 32'd0);
        check("wrap_main", 32'(instr_count), 32'd16);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
